// File: rtl/gpio_port_bank.sv
// Parametrised GPIO bank: NPORT x W-bit bidirectional ports with a 2-flop input
// synchroniser and edge-capture interrupts. Define GPIO_BOTH_EDGE_EN to flag both edges.
module gpio_port_bank #(
    parameter int unsigned NPORT = 4,
    parameter int unsigned W     = 4,
    parameter int unsigned AW    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic [AW-1:0]        addr,
    input  logic [W-1:0]         wdata,
    output logic [W-1:0]         rdata,
    inout  wire  [NPORT*W-1:0]   pins,
    output logic                 irq
);

    localparam int unsigned NB = NPORT * W;
    localparam int unsigned IW = AW - 2;

    logic [NB-1:0] dir_q, dir_d;
    logic [NB-1:0] out_q, out_d;
    logic [NB-1:0] ie_q, ie_d;
    logic [NB-1:0] flag_q, flag_d;
    logic [NB-1:0] sync1_q, sync2_q, prev_q;
    logic [NB-1:0] edge_c;
    logic [NB-1:0] wmask;
    logic [NB-1:0] wbus;
    logic [NB-1:0] clr;
    logic          irq_q;
    logic [IW-1:0] idx;
    logic [1:0]    sel;

    assign idx  = addr[AW-1:2];
    assign sel  = addr[1:0];
    assign wbus = {NPORT{wdata}};

    // Only input-mode, enabled bits can raise an event
`ifdef GPIO_BOTH_EDGE_EN
    assign edge_c = (sync2_q ^ prev_q) & ie_q & dir_q;
`else
    assign edge_c = sync2_q & ~prev_q & ie_q & dir_q;
`endif

    // Per-bit pad driver: input mode releases the pad
    for (genvar i = 0; i < NB; i++) begin : g_pad
        assign pins[i] = dir_q[i] ? 1'bz : out_q[i];
    end

    // Bit mask of the addressed port; stays zero for out-of-range indices
    always_comb begin
        wmask = '0;
        for (int unsigned k = 0; k < NPORT; k++) begin
            if (32'(idx) == k) begin
                wmask[k*W +: W] = '1;
            end
        end
    end

    // Register next-state; an edge event wins over a same-cycle clear
    always_comb begin
        dir_d = dir_q;
        out_d = out_q;
        ie_d  = ie_q;
        clr   = '0;
        if (wr) begin
            case (sel)
                2'd0:    dir_d = (dir_q & ~wmask) | (wbus & wmask);
                2'd1:    out_d = (out_q & ~wmask) | (wbus & wmask);
                2'd2:    ie_d  = (ie_q  & ~wmask) | (wbus & wmask);
                default: clr   = wbus & wmask;
            endcase
        end
        flag_d = edge_c | (flag_q & ~clr);
    end

    // Combinational read mux; OUT reads back the synchronised pad value
    always_comb begin
        rdata = '0;
        for (int unsigned k = 0; k < NPORT; k++) begin
            if (32'(idx) == k) begin
                case (sel)
                    2'd0:    rdata = dir_q[k*W +: W];
                    2'd1:    rdata = sync2_q[k*W +: W];
                    2'd2:    rdata = ie_q[k*W +: W];
                    default: rdata = flag_q[k*W +: W];
                endcase
            end
        end
    end

    // Synchroniser stages reset high so no edge is seen leaving reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q   <= '1;
            out_q   <= '1;
            ie_q    <= '0;
            flag_q  <= '0;
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
            irq_q   <= 1'b0;
        end else begin
            dir_q   <= dir_d;
            out_q   <= out_d;
            ie_q    <= ie_d;
            flag_q  <= flag_d;
            sync1_q <= pins;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            irq_q   <= |(flag_q & ie_q);
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_gpio_port_bank.sv
// Bench for gpio_port_bank: directed scenarios plus randomized traffic against a pin-history model.
module tb_gpio_port_bank;

    localparam int unsigned NPORT = 4;
    localparam int unsigned W     = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned NB    = NPORT * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata;
    logic          irq;
    wire  [NB-1:0] pins;

    logic [NB-1:0] tb_val;
    logic [NB-1:0] tb_oe;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: registers as bit vectors, pad history as the last three sampled values
    logic [NB-1:0] m_dir, m_out, m_ie, m_flag;
    logic          m_irq;
    logic [NB-1:0] hist [3];

    gpio_port_bank #(.NPORT(NPORT), .W(W), .AW(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .pins  (pins),
        .irq   (irq)
    );

    for (genvar i = 0; i < NB; i++) begin : g_drv
        assign pins[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_dir  = '1;
        m_out  = '1;
        m_ie   = '0;
        m_flag = '0;
        m_irq  = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = '1;
    endtask

    function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
        int unsigned idx;
        idx = 32'(a[AW-1:2]);
        if (idx >= NPORT) return '0;
        case (a[1:0])
            2'd0:    return m_dir[idx*W +: W];
            2'd1:    return hist[1][idx*W +: W];
            2'd2:    return m_ie[idx*W +: W];
            default: return m_flag[idx*W +: W];
        endcase
    endfunction

    // One clock with an optional write; advances the model and checks irq
    task automatic cyc(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
        logic [NB-1:0] p, ev, clr;
        int unsigned   idx;
        idx   = 32'(a[AW-1:2]);
        wr    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        p = (m_dir & tb_val) | (~m_dir & m_out);
`ifdef GPIO_BOTH_EDGE_EN
        ev = (hist[1] ^ hist[0]) & m_ie & m_dir;
`else
        ev = hist[1] & ~hist[0] & m_ie & m_dir;
`endif
        m_irq = |(m_flag & m_ie);
        clr   = '0;
        if (w && idx < NPORT) begin
            case (a[1:0])
                2'd0:    m_dir[idx*W +: W] = d;
                2'd1:    m_out[idx*W +: W] = d;
                2'd2:    m_ie[idx*W +: W]  = d;
                default: clr[idx*W +: W]   = d;
            endcase
        end
        m_flag  = ev | (m_flag & ~clr);
        hist[0] = hist[1];
        hist[1] = hist[2];
        hist[2] = p;
        #1;
        wr    = 1'b0;
        tb_oe = m_dir;
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0);
    endtask

    task automatic rd_const(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
        addr = a;
        wr   = 1'b0;
        #1;
        check(tag, 32'(rdata), 32'(exp));
    endtask

    task automatic rd_model(input string tag, input logic [AW-1:0] a);
        addr = a;
        wr   = 1'b0;
        #1;
        check(tag, 32'(rdata), 32'(m_read(a)));
    endtask

    initial begin
        logic [W-1:0] both_exp;
        rst    = 1'b1;
        wr     = 1'b0;
        addr   = '0;
        wdata  = '0;
        tb_oe  = '1;
        tb_val = NB'($urandom) & ~(NB'(1) << 8);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_irq", 32'(irq), 32'(0));
        check("rst_pins_released", 32'(pins), 32'(tb_val));
        rd_const("rst_dir0", 5'h00, 4'hF);
        rd_const("rst_flag0", 5'h03, 4'h0);

        // Port1 as output driving 0xA
        cyc(1'b1, 5'h04, 4'h0);
        cyc(1'b1, 5'h05, 4'hA);
        check("pad_drive_p1", 32'(pins[7:4]), 32'(4'hA));
        idle(2);
        rd_const("out_readback_p1", 5'h05, 4'hA);

        // Rising edge on pins[8] with IE set
        cyc(1'b1, 5'h0A, 4'h1);
        idle(2);
        tb_val[8] = 1'b1;
        idle(2);
        rd_const("flag_early", 5'h0B, 4'h0);
        idle(1);
        rd_const("flag_set", 5'h0B, 4'h1);
        check("irq_not_yet", 32'(irq), 32'(0));
        idle(1);
        check("irq_rise", 32'(irq), 32'(1));
        cyc(1'b1, 5'h0B, 4'h1);
        rd_const("flag_cleared", 5'h0B, 4'h0);
        idle(1);
        check("irq_fall", 32'(irq), 32'(0));

        // Edge event coinciding with a write-1 clear
        tb_val[8] = 1'b0;
        idle(4);
        cyc(1'b1, 5'h0B, 4'h1);
        rd_const("flag_pre_race", 5'h0B, 4'h0);
        tb_val[8] = 1'b1;
        idle(2);
        cyc(1'b1, 5'h0B, 4'h1);
        rd_const("flag_event_wins", 5'h0B, 4'h1);
        cyc(1'b1, 5'h0B, 4'h1);
        idle(2);
        rd_const("flag_race_cleared", 5'h0B, 4'h0);

        // Output-mode bit toggling never flags
        cyc(1'b1, 5'h00, 4'hE);
        cyc(1'b1, 5'h02, 4'h1);
        cyc(1'b1, 5'h01, 4'h0);
        cyc(1'b1, 5'h01, 4'h1);
        cyc(1'b1, 5'h01, 4'h0);
        idle(4);
        rd_const("out_mode_no_flag", 5'h03, 4'h0);
        check("out_mode_no_irq", 32'(irq), 32'(0));

        // Out-of-range port index
        cyc(1'b1, 5'h10, 4'h5);
        cyc(1'b1, 5'h11, 4'h0);
        cyc(1'b1, 5'h12, 4'hF);
        cyc(1'b1, 5'h13, 4'hF);
        rd_const("oor_rd0", 5'h10, 4'h0);
        rd_const("oor_rd2", 5'h12, 4'h0);
        rd_const("oor_dir0_kept", 5'h00, 4'hE);
        rd_const("oor_ie0_kept", 5'h02, 4'h1);

        // Falling edge on pins[8]
        tb_val[8] = 1'b0;
        idle(4);
`ifdef GPIO_BOTH_EDGE_EN
        both_exp = 4'h1;
`else
        both_exp = 4'h0;
`endif
        rd_const("falling_edge_flag", 5'h0B, both_exp);

        // Randomized traffic against the model, with an asynchronous reset midway
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ra;
            tb_val = NB'($urandom);
            ra     = AW'($urandom_range(0, 19));
            cyc(1'(($urandom % 3) == 0), ra, W'($urandom));
            rd_model("rand_rd", AW'($urandom_range(0, 19)));
            if (i == 200) begin
                addr = 5'h00;
                #2 rst = 1'b1;
                #1;
                m_reset();
                tb_oe = '1;
                check("async_rst_irq", 32'(irq), 32'(0));
                check("async_rst_dir", 32'(rdata), 32'(4'hF));
                rd_const("async_rst_flag", 5'h0B, 4'h0);
                @(posedge clk);
                #1 rst = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
